// File: rtl/gf16_reduce_seq_pkg.sv
// Shared types and constants for the GF(2^16) sequential reducer.
package gf16_pkg;
    localparam int          GF_W         = 16;
    localparam int          PROD_W       = 31;
    localparam logic [15:0] POLY_DEFAULT = 16'h002B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Reduction cycles for a given per-cycle bit count; 0 flags an unsupported value.
    function automatic int steps_f(input int s);
        return (s == 1 || s == 3 || s == 5 || s == 15) ? 15 / s : 0;
    endfunction
endpackage

// File: rtl/gf16_reduce_seq_if.sv
// Product-in / remainder-out handshake bundle for gf16_reduce_seq.
interface gf16_reduce_seq_if;
    import gf16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [GF_W-1:0]   out_rem;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_rem
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_rem
    );
endinterface

// File: rtl/gf16_reduce_seq_step.sv
// One reduction step: clears S product bits from top_idx downward by folding in the modulus.
module gf16_reduce_step
    import gf16_pkg::*;
#(
    parameter int              S    = 3,
    parameter logic [GF_W-1:0] POLY = POLY_DEFAULT
) (
    input  logic [PROD_W-1:0] w_in,
    input  logic [4:0]        top_idx,
    output logic [PROD_W-1:0] w_out
);
    localparam logic [PROD_W-1:0] MOD = PROD_W'({1'b1, POLY});

    logic [PROD_W-1:0] acc;
    logic [4:0]        bit_idx;

    // Bits above bit_idx are already clear, so each fold only reaches bit_idx and below.
    always_comb begin
        acc     = w_in;
        bit_idx = top_idx;
        for (int k = 0; k < S; k++) begin
            bit_idx = top_idx - 5'(k);
            if (acc[bit_idx]) begin
                acc = acc ^ (MOD << (bit_idx - 5'd16));
            end
        end
        w_out = acc;
    end
endmodule

// File: rtl/gf16_reduce_seq.sv
// Iterative reducer of a 31-bit carry-less product modulo x^16 + POLY, S bits per clock.
module gf16_reduce_seq
    import gf16_pkg::*;
#(
    parameter int              S    = 3,
    parameter logic [GF_W-1:0] POLY = POLY_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    gf16_reduce_seq_if.slave bus
);
    localparam int STEPS = steps_f(S);
    localparam int CNT_W = (STEPS > 0) ? $clog2(STEPS + 1) : 1;

    if (STEPS == 0) begin : g_bad_s
        $error("gf16_reduce_seq: S must be 1, 3, 5 or 15");
    end

    state_t            state, state_n;
    logic [PROD_W-1:0] w, w_n, w_step;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [GF_W-1:0]   rem, rem_n;
    logic [4:0]        top_idx;

    assign top_idx = 5'(PROD_W - 1 - S * int'(cnt));

    gf16_reduce_step #(.S(S), .POLY(POLY)) u_step (
        .w_in    (w),
        .top_idx (top_idx),
        .w_out   (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            w     <= '0;
            cnt   <= '0;
            rem   <= '0;
        end else begin
            state <= state_n;
            w     <= w_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n = state;
        w_n     = w;
        cnt_n   = cnt;
        rem_n   = rem;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_n     = bus.in_prod;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                w_n   = w_step;
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_W'(STEPS - 1)) begin
                    rem_n   = w_step[GF_W-1:0];
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Ready drops combinationally with rst so nothing is accepted during reset.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_rem   = rem;
endmodule
